// File: rtl/sha_blk_rx_pkg.sv
// Shared SHA word-stream constants and helpers for the block receiver.
package sha_blk_rx_pkg;
  localparam int SHA_WORD_W    = 32;
  localparam int SHA_BLK_WORDS = 16;
  // Padding tail for a 256-bit message: 0x80 marker, zero fill, length 0x100.
  localparam logic [255:0] SHA_PAD_TAIL =
    256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000100;

  typedef logic [SHA_WORD_W-1:0] sha_word_t;

  function automatic sha_word_t pad_tail_word(input int idx);
    return SHA_PAD_TAIL[255-SHA_WORD_W*idx -: SHA_WORD_W];
  endfunction
endpackage

// File: rtl/sha_blk_rx_if.sv
// Word-stream input, block handshake output and status of the block receiver.
interface sha_blk_rx_if
  import sha_blk_rx_pkg::*;
#(
  parameter int DW = SHA_WORD_W,
  parameter int NW = SHA_BLK_WORDS
);
  logic             clr;
  logic             din_vld;
  logic [DW-1:0]    din;
  logic             din_first;
  logic             blk_vld;
  logic             blk_rdy;
  logic [DW*NW-1:0] blk_data;
  logic             blk_first;
  logic             busy;
  logic             ovf;

  modport master (
    output clr, din_vld, din, din_first, blk_rdy,
    input  blk_vld, blk_data, blk_first, busy, ovf
  );

  modport slave (
    input  clr, din_vld, din, din_first, blk_rdy,
    output blk_vld, blk_data, blk_first, busy, ovf
  );
endinterface

// File: rtl/sha_blk_rx_buf.sv
// One NW x DW word bank with indexed write, block-first flag and MSB-first flat read-out.
module sha_blk_rx_buf
  import sha_blk_rx_pkg::*;
#(
  parameter int DW = SHA_WORD_W,
  parameter int NW = SHA_BLK_WORDS,
  parameter int CW = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [CW-1:0]    i_idx,
  input  logic [DW-1:0]    i_word,
  input  logic             i_first,
  output logic [DW*NW-1:0] o_data,
  output logic             o_first
);
  logic [DW-1:0] r_words [NW];
  logic          r_first;

  // Payload storage only; no reset so contents survive as plain data.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_words[i_idx] <= i_word;
      if (i_idx == '0) r_first <= i_first;
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_flat
    assign o_data[DW*(NW-1-g) +: DW] = r_words[g];
  end

  assign o_first = r_first;
endmodule

// File: rtl/sha_blk_rx.sv
// Packs the 32-bit word stream into 512-bit blocks via a ping-pong pair and hands them to the SHA core.
module sha_blk_rx
  import sha_blk_rx_pkg::*;
#(
  parameter int DW = SHA_WORD_W,
  parameter int NW = SHA_BLK_WORDS
) (
  input logic         clk,
  input logic         rst,
  sha_blk_rx_if.slave bus
);
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  logic [CW-1:0]    r_wcnt;
  logic             r_wr_sel;
  logic             r_rd_sel;
  logic [1:0]       r_full;
  logic             r_ovf;

  logic             w_acc;
  logic [CW-1:0]    w_slot;
  logic             w_last;
  logic             w_xfer;
  logic [1:0]       w_we;
  logic [1:0]       w_full_nxt;
  logic [DW*NW-1:0] w_data [2];
  logic [1:0]       w_first;

  // Fullness is sampled before the edge, so a buffer freed this cycle still rejects the word.
  assign w_acc  = bus.din_vld & ~r_full[r_wr_sel] & ~bus.clr;
  assign w_slot = bus.din_first ? '0 : r_wcnt;
  assign w_last = (w_slot == CW'(NW-1));
  assign w_xfer = r_full[r_rd_sel] & bus.blk_rdy;
  assign w_we   = {w_acc & r_wr_sel, w_acc & ~r_wr_sel};

  for (genvar g = 0; g < 2; g++) begin : g_buf
    sha_blk_rx_buf #(.DW(DW), .NW(NW), .CW(CW)) u_buf (
      .clk    (clk),
      .i_we   (w_we[g]),
      .i_idx  (w_slot),
      .i_word (bus.din),
      .i_first(bus.din_first),
      .o_data (w_data[g]),
      .o_first(w_first[g])
    );
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_acc && w_last) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_xfer)          w_full_nxt[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_full   <= '0;
      r_ovf    <= 1'b0;
    end else if (bus.clr) begin
      r_wcnt   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_full   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_wcnt <= w_last ? '0 : w_slot + 1'b1;
        if (w_last) r_wr_sel <= ~r_wr_sel;
      end
      if (bus.din_vld && r_full[r_wr_sel]) r_ovf <= 1'b1;
      r_full <= w_full_nxt;
      if (w_xfer) r_rd_sel <= ~r_rd_sel;
    end
  end

  // Data and flag are forced to 0 when idle so every output reads 0 after reset or flush.
  assign bus.blk_vld   = r_full[r_rd_sel];
  assign bus.blk_data  = r_full[r_rd_sel] ? w_data[r_rd_sel] : '0;
  assign bus.blk_first = r_full[r_rd_sel] & w_first[r_rd_sel];
  assign bus.busy      = (r_wcnt != '0) | r_full[0] | r_full[1];
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_sha_blk_rx.sv
// Scoreboard bench for sha_blk_rx: directed word streams, expected blocks queued, monitor compares transfers.
module tb_sha_blk_rx;
  import sha_blk_rx_pkg::*;

  typedef struct {
    logic [511:0] d;
    logic         f;
  } blk_t;

  logic clk;
  logic rst;
  sha_blk_rx_if bus ();

  sha_blk_rx dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  blk_t sb_q[$];
  int   n_run = 0;
  int   n_fail = 0;
  int   n_rx = 0;
  int   n_vld_cyc = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_seq(input logic [31:0] base);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = base + 32'(i);
    return b;
  endfunction

  task automatic push(input logic [511:0] d, input logic f);
    blk_t e;
    e.d = d;
    e.f = f;
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; leaves the word on the bus across exactly one edge.
  task automatic send(input logic [31:0] w, input logic f);
    bus.din_vld   = 1'b1;
    bus.din       = w;
    bus.din_first = f;
    @(posedge clk); #1;
    bus.din_vld   = 1'b0;
    bus.din_first = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int max_cyc);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < max_cyc) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Monitor: checks every transfer against the queue and the hold rules between transfers.
  initial begin
    logic         p_vld, p_xfer, p_clr;
    logic [511:0] p_data;
    blk_t         e;
    p_vld = 1'b0; p_xfer = 1'b0; p_clr = 1'b0; p_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_vld = 1'b0;
      end else begin
        if (bus.blk_vld) n_vld_cyc++;
        if (p_vld && !p_xfer && !p_clr) begin
          chk("hold blk_vld", bus.blk_vld, 1);
          if (bus.blk_vld) chk("hold blk_data", bus.blk_data, p_data);
        end
        if (bus.blk_vld && bus.blk_rdy) begin
          n_rx++;
          if (sb_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected block: got %0h first=%0b, none expected", bus.blk_data, bus.blk_first);
          end else begin
            e = sb_q.pop_front();
            chk("blk_data", bus.blk_data, e.d);
            chk("blk_first", bus.blk_first, e.f);
          end
        end
        p_vld  = bus.blk_vld;
        p_xfer = bus.blk_vld && bus.blk_rdy;
        p_data = bus.blk_data;
        p_clr  = bus.clr;
      end
    end
  end

  initial begin
    logic [31:0]  h [8];
    logic [511:0] exp_blk;
    int           rx0;

    rst = 1'b1;
    bus.clr = 1'b0; bus.din_vld = 1'b0; bus.din = '0; bus.din_first = 1'b0; bus.blk_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset blk_vld", bus.blk_vld, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset ovf", bus.ovf, 0);
    chk("reset blk_first", bus.blk_first, 0);
    chk("reset blk_data", bus.blk_data, 0);

    // T1 basic block
    bus.blk_rdy = 1'b1;
    n_vld_cyc = 0;
    push(mk_seq(32'h0), 1'b1);
    for (int i = 0; i < 16; i++) send(32'(i), i == 0);
    chk("T1 vld after last word", bus.blk_vld, 1);
    chk("T1 first", bus.blk_first, 1);
    cyc(1);
    chk("T1 vld drops", bus.blk_vld, 0);
    cyc(3);
    chk("T1 vld cycles", n_vld_cyc, 1);
    wait_drain("T1 drain", 4);

    // T2 ping-pong under stall
    bus.blk_rdy = 1'b0;
    push(mk_seq(32'h100), 1'b0);
    push(mk_seq(32'h110), 1'b0);
    for (int i = 0; i < 32; i++) send(32'h100 + 32'(i), 1'b0);
    chk("T2 ovf", bus.ovf, 0);
    chk("T2 busy", bus.busy, 1);
    chk("T2 vld", bus.blk_vld, 1);
    chk("T2 word0 A", bus.blk_data[511:480], 32'h100);
    bus.blk_rdy = 1'b1;
    wait_drain("T2 drain", 10);
    cyc(1);
    chk("T2 idle busy", bus.busy, 0);

    // T3 overflow
    bus.blk_rdy = 1'b0;
    push(mk_seq(32'h100), 1'b0);
    push(mk_seq(32'h110), 1'b0);
    for (int i = 0; i < 32; i++) send(32'h100 + 32'(i), 1'b0);
    send(32'hDEADBEEF, 1'b0);
    chk("T3 ovf set", bus.ovf, 1);
    chk("T3 word0 A kept", bus.blk_data[511:480], 32'h100);
    cyc(2);
    bus.blk_rdy = 1'b1;
    wait_drain("T3 drain", 10);
    chk("T3 ovf sticky", bus.ovf, 1);
    for (int i = 0; i < 3; i++) send(32'h300 + 32'(i), 1'b0);
    chk("T3 partial busy", bus.busy, 1);
    do_clr();
    chk("T3 clr ovf", bus.ovf, 0);
    chk("T3 clr vld", bus.blk_vld, 0);
    chk("T3 clr busy", bus.busy, 0);

    // T4 restart
    rx0 = n_rx;
    exp_blk = mk_seq(32'h1FF);
    exp_blk[511:480] = 32'hA5A5A5A5;
    push(exp_blk, 1'b1);
    for (int i = 0; i < 5; i++) send(32'h50 + 32'(i), 1'b0);
    send(32'hA5A5A5A5, 1'b1);
    for (int i = 0; i < 15; i++) send(32'h200 + 32'(i), 1'b0);
    wait_drain("T4 drain", 10);
    cyc(3);
    chk("T4 block count", n_rx - rx0, 1);

    // T5 dbl-SHA second pass
    h[0] = 32'h6a09e667; h[1] = 32'hbb67ae85; h[2] = 32'h3c6ef372; h[3] = 32'ha54ff53a;
    h[4] = 32'h510e527f; h[5] = 32'h9b05688c; h[6] = 32'h1f83d9ab; h[7] = 32'h5be0cd19;
    exp_blk = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7], SHA_PAD_TAIL};
    push(exp_blk, 1'b1);
    for (int i = 0; i < 8; i++) send(h[i], i == 0);
    for (int i = 0; i < 8; i++) send(pad_tail_word(i), 1'b0);
    wait_drain("T5 drain", 10);

    // T6 async reset mid-block, then mid-handshake
    for (int i = 0; i < 9; i++) send(32'h400 + 32'(i), i == 0);
    chk("T6 busy mid-block", bus.busy, 1);
    rst = 1'b1;
    #2;
    chk("T6a busy", bus.busy, 0);
    chk("T6a vld", bus.blk_vld, 0);
    chk("T6a ovf", bus.ovf, 0);
    @(posedge clk); #1 rst = 1'b0;
    bus.blk_rdy = 1'b0;
    for (int i = 0; i < 33; i++) send(32'h600 + 32'(i), 1'b0);
    chk("T6 pre vld", bus.blk_vld, 1);
    chk("T6 pre ovf", bus.ovf, 1);
    #3 rst = 1'b1;
    #1;
    chk("T6b vld", bus.blk_vld, 0);
    chk("T6b busy", bus.busy, 0);
    chk("T6b ovf", bus.ovf, 0);
    @(posedge clk); #1 rst = 1'b0;
    bus.blk_rdy = 1'b1;
    push(mk_seq(32'h500), 1'b1);
    for (int i = 0; i < 16; i++) send(32'h500 + 32'(i), i == 0);
    wait_drain("T6 fresh drain", 10);
    cyc(3);
    chk("final queue empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, limit 200000");
    $fatal(1);
  end
endmodule
